rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Downstream consumer of the power-on auto-reset stage.
- Takes the combined system reset and the PLL lock indication.
- Once lock has been stable for a set time, releases a vector of per-subsystem active-low resets one at a time, with a fixed gap between releases.
- Re-asserts all stage resets whenever lock is lost or a soft reset is requested, then restarts the sequence.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (1..16)
LOCK_STABLE_CNT, 256, consecutive cycles of synchronized lock required before the first release (>=1)
STAGE_GAP_CNT, 64, cycles between consecutive stage releases, and between the last release and done (>=1)
TIMEOUT_CNT, 65535, cycles without a completed lock qualification before flagging a timeout (used only with RST_SEQ_TIMEOUT_EN)
CNT_W, 16, width of the internal counters; must hold max(LOCK_STABLE_CNT, STAGE_GAP_CNT, TIMEOUT_CNT)

Ports:
i_sys_clk  in  1  system clock
i_rst_in  in  1  synchronous, active-high reset
i_pll_locked  in  1  PLL lock, asynchronous to i_sys_clk
i_soft_rst  in  1  level; while high, the sequence is held in restart
o_rst_n  out  NUM_STAGES  per-stage active-low resets; bit 0 is released first
o_seq_done  out  1  high once all stages are released and the final gap has elapsed
o_stage_cnt  out  5  number of stages currently released
o_lock_lost  out  1  one-cycle pulse on loss of lock after the first release
o_lock_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (i_rst_in=1 at an edge):
  - state=WAIT_LOCK; counters=0; sync flops=0.
  - o_rst_n=all 0; o_seq_done=0; o_stage_cnt=0; o_lock_lost=0; o_lock_timeout=0.
  - i_rst_in overrides every other input.
- i_pll_locked passes through a 2-flop synchronizer. lock_s is the synchronizer output and adds 2 cycles of latency.
- All outputs are registered. No combinational path from any input to any output.
- FSM states and transitions:
  - WAIT_LOCK: o_rst_n all 0. If lock_s=1 and i_soft_rst=0: go to QUALIFY, cnt=0.
  - QUALIFY: cnt increments while lock_s=1. If lock_s=0 or i_soft_rst=1: go to WAIT_LOCK, cnt=0. When cnt==LOCK_STABLE_CNT-1: go to RELEASE, idx=0, cnt=0, and o_rst_n[0] is driven to 1 on that same edge.
  - RELEASE: cnt counts 0..STAGE_GAP_CNT-1 and then wraps to 0. On each wrap with idx<NUM_STAGES-1: idx++ and o_rst_n[idx] is driven to 1. On the wrap with idx==NUM_STAGES-1: go to DONE and o_seq_done is driven to 1.
  - DONE: all o_rst_n=1; o_seq_done=1; held here.
- Latency: with lock held high, o_rst_n[0] rises at edge LOCK_STABLE_CNT+3, counting the first edge that samples i_pll_locked high as edge 1.
  - o_rst_n[k] rises k*STAGE_GAP_CNT cycles after o_rst_n[0].
  - o_seq_done rises STAGE_GAP_CNT cycles after o_rst_n[NUM_STAGES-1].
- Abort (lock_s=0 or i_soft_rst=1 while in RELEASE or DONE):
  - On the next edge: all o_rst_n=0, o_seq_done=0, o_stage_cnt=0, state=WAIT_LOCK, counters=0.
  - o_lock_lost pulses for one cycle only if the cause is lock_s=0.
  - If lock loss and soft reset occur together, o_lock_lost still pulses.
- Reset assertion is always simultaneous across all stages. Release is always in ascending order. Bits never release out of order.
- o_stage_cnt equals the number of o_rst_n bits that are 1, and updates on the same edge as o_rst_n.
- Glitches on lock_s during QUALIFY restart qualification from 0. Partial counts are never retained.
- Counters never wrap beyond their terminal value. The DONE state holds cnt.

Optional Feature:
- Macro RST_SEQ_TIMEOUT_EN.
- Defined:
  - A timeout counter increments each cycle in WAIT_LOCK or QUALIFY.
  - It clears on entering RELEASE.
  - It saturates at TIMEOUT_CNT-1.
  - On reaching TIMEOUT_CNT-1, o_lock_timeout is set to 1 and stays set until i_rst_in.
  - Sequencing continues unaffected.
- Not defined: no timeout counter; o_lock_timeout is constant 0.

Decomposition:
- Shared package rst_seq_pkg:
  - FSM state encodings: WAIT_LOCK=2'd0, QUALIFY=2'd1, RELEASE=2'd2, DONE=2'd3.
  - Stage-count width constant (5).
- Sub-module sync_2ff (1-bit, 2-flop synchronizer):
  - Used for i_pll_locked.
  - Its flops are reset to 0 by i_rst_in.

Test Plan (NUM_STAGES=3, LOCK_STABLE_CNT=4, STAGE_GAP_CNT=2, TIMEOUT_CNT=20 unless stated):
1. Hold i_rst_in=1 for 5 cycles with i_pll_locked=1 -> o_rst_n=3'b000, o_seq_done=0, o_stage_cnt=0 throughout.
2. Release reset, then raise lock and hold it -> o_rst_n[0] rises at edge 7, [1] at edge 9, [2] at edge 11, o_seq_done at edge 13, o_stage_cnt steps 1,2,3.
3. Drop lock for 1 cycle during QUALIFY (after 2 qualified cycles) -> no release. First release occurs 7 edges after lock is seen high again.
4. Drop lock in DONE -> 2 edges later (synchronizer) plus 1: o_rst_n=000, o_seq_done=0, one-cycle o_lock_lost; sequence repeats from WAIT_LOCK once lock returns.
5. Assert i_soft_rst for 1 cycle during RELEASE with idx=1 -> next edge o_rst_n=000, no o_lock_lost pulse, full sequence restarts.
6. With RST_SEQ_TIMEOUT_EN defined, keep lock low -> o_lock_timeout rises at edge 20 and stays high after lock arrives and the sequence completes. Without the macro, o_lock_timeout stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and the
// width of the released-stage count.
package rst_seq_pkg;

  // Width of the released-stage count (holds 0..16)
  localparam int STAGE_CNT_W = 5;

  typedef logic [STAGE_CNT_W-1:0] stage_cnt_t;
  typedef logic [1:0]             seq_state_t;

  // Sequencer states
  localparam seq_state_t WAIT_LOCK = 2'd0;
  localparam seq_state_t QUALIFY   = 2'd1;
  localparam seq_state_t RELEASE   = 2'd2;
  localparam seq_state_t DONE      = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for a level coming from another clock
// domain. Both flops clear on the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Shift the asynchronous level through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer. Waits for the PLL lock to be stable for LOCK_STABLE_CNT
// cycles, then releases the active-low stage resets one by one (bit 0 first)
// spaced STAGE_GAP_CNT cycles apart, and flags completion one gap after the
// last release. Loss of lock or a soft reset re-asserts every stage at once
// and restarts the sequence.
// Optional build macro RST_SEQ_TIMEOUT_EN adds a sticky lock-timeout flag.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES      = 4,
  parameter int LOCK_STABLE_CNT = 256,
  parameter int STAGE_GAP_CNT   = 64,
  parameter int TIMEOUT_CNT     = 65535,
  parameter int CNT_W           = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_in,
  input  logic                  i_pll_locked,
  input  logic                  i_soft_rst,
  output logic [NUM_STAGES-1:0] o_rst_n,
  output logic                  o_seq_done,
  output logic [4:0]            o_stage_cnt,
  output logic                  o_lock_lost,
  output logic                  o_lock_timeout
);

  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CNT - 1);
  localparam stage_cnt_t       LAST_IDX  = STAGE_CNT_W'(NUM_STAGES - 1);

  // Reject parameter sets the counters or output vector cannot represent
  if (NUM_STAGES < 1 || NUM_STAGES > 16 ||
      LOCK_STABLE_CNT < 1 || STAGE_GAP_CNT < 1 || TIMEOUT_CNT < 1 ||
      longint'(LOCK_STABLE_CNT) >= (longint'(1) << CNT_W) ||
      longint'(STAGE_GAP_CNT)   >= (longint'(1) << CNT_W) ||
      longint'(TIMEOUT_CNT)     >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("rst_sequencer: illegal parameter set");
  end

  // Thermometer mask: the lowest n stage bits are released
  function automatic logic [NUM_STAGES-1:0] stage_mask(input stage_cnt_t n);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (STAGE_CNT_W'(i) < n);
    end
    return m;
  endfunction

  logic lock_s;
  logic abort;

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  stage_cnt_t            idx_q, idx_d;
  stage_cnt_t            stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  lost_q, lost_d;
  logic [NUM_STAGES-1:0] rst_n_q;

  sync_2ff u_lock_sync (
    .clk (i_sys_clk),
    .rst (i_rst_in),
    .d   (i_pll_locked),
    .q   (lock_s)
  );

  // Any reason to drop back and re-assert all stages
  assign abort = !lock_s || i_soft_rst;

  // Next-state and next-output computation for the sequencing FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    lost_d  = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        stage_d = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
        if (lock_s && !i_soft_rst) begin
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (abort) begin
          // Any glitch discards the partial qualification
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == QUAL_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = STAGE_CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
          lost_d  = !lock_s;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + STAGE_CNT_W'(1);
            stage_d = stage_q + STAGE_CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
          lost_d  = !lock_s;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; the reset mask is derived from the
  // same stage count so o_stage_cnt always matches the released bits
  always_ff @(posedge i_sys_clk) begin
    if (i_rst_in) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
      rst_n_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
      rst_n_q <= stage_mask(stage_d);
    end
  end

  assign o_rst_n     = rst_n_q;
  assign o_seq_done  = done_q;
  assign o_stage_cnt = stage_q;
  assign o_lock_lost = lost_q;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CNT - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_flag_q;
  logic             pre_release;

  assign pre_release = (state_q == WAIT_LOCK) || (state_q == QUALIFY);

  // Count cycles spent before a completed qualification; flag is sticky
  always_ff @(posedge i_sys_clk) begin
    if (i_rst_in) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (pre_release && tmo_cnt_q == TMO_LAST) begin
        tmo_flag_q <= 1'b1;
      end
      if (state_q == QUALIFY && state_d == RELEASE) begin
        tmo_cnt_q <= '0;
      end else if (pre_release && tmo_cnt_q != TMO_LAST) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_lock_timeout = tmo_flag_q;
`else
  assign o_lock_timeout = 1'b0;
`endif

endmodule
